sm83_irq_ctrl: RTL and testbench

// - Interrupt responder on the far side of the CPU's IF/IE/dispatch path: owns IF (0xFF0F) and IE (0xFFFF),

---
 rtl/sm83_pkg.sv | 23 ++
 rtl/sm83_irq_prio_enc.sv | 21 ++
 rtl/sm83_irq_ctrl.sv | 122 ++++++++++++
 tb/tb_sm83_irq_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 types: bus address, interrupt source ids and dispatch states.
// Optional build macro consumed by the interrupt block: SM83_IRQ_EDGE_DETECT_EN.
package sm83_pkg;

    typedef logic [15:0] addr_t;

    typedef enum logic [2:0] {
        IRQ_VBLANK = 3'd0,
        IRQ_STAT   = 3'd1,
        IRQ_TIMER  = 3'd2,
        IRQ_SERIAL = 3'd3,
        IRQ_JOYPAD = 3'd4
    } irq_src_t;

    typedef enum logic [0:0] {
        IRQ_IDLE     = 1'b0,
        IRQ_DISPATCH = 1'b1
    } irq_state_t;

    localparam addr_t ADDR_IF = 16'hFF0F;
    localparam addr_t ADDR_IE = 16'hFFFF;

endpackage

// File: rtl/sm83_irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the mask wins.
// Purely combinational helper for the interrupt controller.
module sm83_irq_prio_enc #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  mask,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = |mask;
        idx = '0;
        // Scan downwards so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt responder: IF/IE registers, request capture, dispatch vector.
// Define SM83_IRQ_EDGE_DETECT_EN to latch only rising edges of irq_src.
module sm83_irq_ctrl
    import sm83_pkg::*;
#(
    parameter int    NUM_IRQ    = 5,
    parameter addr_t IF_ADDR    = ADDR_IF,
    parameter addr_t IE_ADDR    = ADDR_IE,
    parameter addr_t VEC_BASE   = 16'h0040,
    parameter int    VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  addr_t              bus_addr,
    input  logic               bus_wen,
    input  logic               bus_ren,
    input  logic [7:0]         bus_wdata,
    output logic [7:0]         bus_rdata,
    output logic               bus_rvalid,
    output logic               irq_pending,
    output logic               halt_wake,
    input  logic               irq_ack_start,
    input  logic               irq_ack_commit,
    output logic [15:0]        irq_vec,
    output logic               irq_vec_valid
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [NUM_IRQ-1:0] set_mask, clr_mask, act;
    logic [7:0]         ie_q, if_rd;
    logic [15:0]        vec_d;
    logic [IW-1:0]      idx;
    logic               any, commit_fire;
    logic               wr_if, wr_ie, rd_if, rd_ie;
    irq_state_t         state_q, state_d;

    assign wr_if = bus_wen && (bus_addr == IF_ADDR);
    assign wr_ie = bus_wen && (bus_addr == IE_ADDR);
    assign rd_if = bus_ren && (bus_addr == IF_ADDR);
    assign rd_ie = bus_ren && (bus_addr == IE_ADDR);

    assign act         = if_q & ie_q[NUM_IRQ-1:0];
    assign irq_pending = |act;
    assign halt_wake   = irq_pending;

`ifdef SM83_IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] src_q;

    always_ff @(posedge clk) begin
        if (rst) src_q <= '0;
        else     src_q <= irq_src;
    end

    assign set_mask = irq_src & ~src_q;
`else
    assign set_mask = irq_src;
`endif

    sm83_irq_prio_enc #(
        .N  (NUM_IRQ),
        .IW (IW)
    ) u_prio (
        .mask (act),
        .any  (any),
        .idx  (idx)
    );

    always_comb begin
        state_d     = state_q;
        commit_fire = 1'b0;
        unique case (state_q)
            IRQ_IDLE: begin
                if (irq_ack_start) state_d = IRQ_DISPATCH;
            end
            IRQ_DISPATCH: begin
                if (irq_ack_commit) begin
                    state_d     = IRQ_IDLE;
                    commit_fire = 1'b1;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        vec_d    = '0;
        if (commit_fire && any) begin
            clr_mask = NUM_IRQ'(1) << idx;
            vec_d    = VEC_BASE + 16'(idx) * 16'(VEC_STRIDE);
        end
        // Set is applied last so a new request survives writes and acks.
        if_d = ((wr_if ? bus_wdata[NUM_IRQ-1:0] : if_q) & ~clr_mask) | set_mask;
        if_rd = '1;
        if_rd[NUM_IRQ-1:0] = if_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IRQ_IDLE;
            if_q          <= '0;
            ie_q          <= '0;
            bus_rdata     <= '0;
            bus_rvalid    <= 1'b0;
            irq_vec       <= '0;
            irq_vec_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            if_q          <= if_d;
            irq_vec_valid <= commit_fire;
            bus_rvalid    <= rd_if | rd_ie;
            if (wr_ie)       ie_q      <= bus_wdata;
            if (commit_fire) irq_vec   <= vec_d;
            if (rd_if)       bus_rdata <= if_rd;
            else if (rd_ie)  bus_rdata <= ie_q;
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Self-checking bench for sm83_irq_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural model of IF/IE/dispatch.
module tb_sm83_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  irq_src;
    logic [15:0] bus_addr;
    logic        bus_wen, bus_ren;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        bus_rvalid, irq_pending, halt_wake;
    logic        irq_ack_start, irq_ack_commit;
    logic [15:0] irq_vec;
    logic        irq_vec_valid;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [4:0]  m_if, m_srcq;
    logic [7:0]  m_ie, m_rd;
    logic        m_disp, m_vv, m_rv;
    logic [15:0] m_vec;

    sm83_irq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src        (irq_src),
        .bus_addr       (bus_addr),
        .bus_wen        (bus_wen),
        .bus_ren        (bus_ren),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_rvalid     (bus_rvalid),
        .irq_pending    (irq_pending),
        .halt_wake      (halt_wake),
        .irq_ack_start  (irq_ack_start),
        .irq_ack_commit (irq_ack_commit),
        .irq_vec        (irq_vec),
        .irq_vec_valid  (irq_vec_valid)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [4:0] set, clr, m;
        if (rst) begin
            m_if = 0; m_ie = 0; m_disp = 0; m_vec = 0;
            m_vv = 0; m_rd = 0; m_rv = 0; m_srcq = 0;
            return;
        end
`ifdef SM83_IRQ_EDGE_DETECT_EN
        set = irq_src & ~m_srcq;
`else
        set = irq_src;
`endif
        m_srcq = irq_src;
        clr = 0;
        m_vv = 0;
        m = m_if & m_ie[4:0];
        if (m_disp && irq_ack_commit) begin
            m_disp = 0;
            m_vv = 1;
            m_vec = 16'h0000;
            for (int i = 4; i >= 0; i--) begin
                if (m[i]) begin
                    m_vec = 16'h0040 + 16'(8 * i);
                    clr = 5'(1 << i);
                end
            end
        end else if (!m_disp && irq_ack_start) begin
            m_disp = 1;
        end
        m_rv = 0;
        if (bus_ren && bus_addr == 16'hFF0F) begin
            m_rd = {3'b111, m_if};
            m_rv = 1;
        end else if (bus_ren && bus_addr == 16'hFFFF) begin
            m_rd = m_ie;
            m_rv = 1;
        end
        if (bus_wen && bus_addr == 16'hFF0F) m_if = bus_wdata[4:0];
        m_if = (m_if & ~clr) | set;
        if (bus_wen && bus_addr == 16'hFFFF) m_ie = bus_wdata;
    endtask

    // One clock: model consumes current inputs, then strobes drop.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        bus_wen = 0;
        bus_ren = 0;
        irq_ack_start = 0;
        irq_ack_commit = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_addr = a; bus_wdata = d; bus_wen = 1;
        cycle();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                            output logic v);
        bus_addr = a; bus_ren = 1;
        cycle();
        d = bus_rdata;
        v = bus_rvalid;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic v;
        irq_src = 0; bus_addr = 0; bus_wdata = 0;
        bus_wen = 0; bus_ren = 0;
        irq_ack_start = 0; irq_ack_commit = 0;
        do_reset();
        checks += 5;
        if (irq_pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending got=%b exp=0", irq_pending);
        end
        if (bus_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid got=%b exp=0", bus_rvalid);
        end
        if (bus_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_rdata got=%h exp=00", bus_rdata);
        end
        if (irq_vec !== 16'h0000) begin
            errors++; $display("FAIL reset_vec got=%h exp=0000", irq_vec);
        end
        if (irq_vec_valid !== 1'b0) begin
            errors++; $display("FAIL reset_vvalid got=%b exp=0", irq_vec_valid);
        end
        bus_read(16'hFF0F, d, v);
        checks++;
        if (d !== 8'hE0 || v !== 1'b1) begin
            errors++; $display("FAIL reset_if_read got=%h/%b exp=e0/1", d, v);
        end
    endtask

    task automatic test_single_dispatch();
        logic [7:0] d;
        logic v;
        do_reset();
        bus_write(16'hFFFF, 8'h1F);
        irq_src = 5'b00100;
        cycle();
        irq_src = 0;
        irq_ack_start = 1;
        cycle();
        cycle();
        cycle();
        irq_ack_commit = 1;
        cycle();
        checks += 2;
        if (irq_vec !== 16'h0050) begin
            errors++; $display("FAIL timer_vec got=%h exp=0050", irq_vec);
        end
        if (irq_vec_valid !== 1'b1) begin
            errors++; $display("FAIL timer_vvalid got=%b exp=1", irq_vec_valid);
        end
        bus_read(16'hFF0F, d, v);
        checks += 3;
        if (irq_vec_valid !== 1'b0) begin
            errors++; $display("FAIL timer_vvalid_pulse got=%b exp=0", irq_vec_valid);
        end
        if (irq_vec !== 16'h0050) begin
            errors++; $display("FAIL timer_vec_hold got=%h exp=0050", irq_vec);
        end
        if (d !== 8'hE0) begin
            errors++; $display("FAIL timer_if_clr got=%h exp=e0", d);
        end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        logic v;
        do_reset();
        bus_write(16'hFF0F, 8'h05);
        bus_write(16'hFFFF, 8'h05);
        irq_ack_start = 1;
        cycle();
        irq_ack_commit = 1;
        cycle();
        checks++;
        if (irq_vec !== 16'h0040 || irq_vec_valid !== 1'b1) begin
            errors++; $display("FAIL prio_first got=%h/%b exp=0040/1", irq_vec, irq_vec_valid);
        end
        bus_read(16'hFF0F, d, v);
        checks++;
        if (d !== 8'hE4) begin
            errors++; $display("FAIL prio_if1 got=%h exp=e4", d);
        end
        irq_ack_start = 1;
        cycle();
        irq_ack_commit = 1;
        cycle();
        checks++;
        if (irq_vec !== 16'h0050 || irq_vec_valid !== 1'b1) begin
            errors++; $display("FAIL prio_second got=%h/%b exp=0050/1", irq_vec, irq_vec_valid);
        end
        bus_read(16'hFF0F, d, v);
        checks++;
        if (d !== 8'hE0) begin
            errors++; $display("FAIL prio_if2 got=%h exp=e0", d);
        end
    endtask

    task automatic test_cancel_and_ignore();
        logic [7:0] d;
        logic v;
        do_reset();
        bus_write(16'hFF0F, 8'h01);
        bus_write(16'hFFFF, 8'h01);
        // commit while idle must do nothing
        irq_ack_commit = 1;
        cycle();
        checks++;
        if (irq_vec_valid !== 1'b0) begin
            errors++; $display("FAIL idle_commit got=%b exp=0", irq_vec_valid);
        end
        irq_ack_start = 1;
        cycle();
        bus_write(16'hFFFF, 8'h00);
        irq_ack_commit = 1;
        cycle();
        checks += 2;
        if (irq_vec !== 16'h0000 || irq_vec_valid !== 1'b1) begin
            errors++; $display("FAIL cancel_vec got=%h/%b exp=0000/1", irq_vec, irq_vec_valid);
        end
        if (irq_pending !== 1'b0) begin
            errors++; $display("FAIL cancel_pending got=%b exp=0", irq_pending);
        end
        bus_read(16'hFF0F, d, v);
        checks++;
        if (d !== 8'hE1) begin
            errors++; $display("FAIL cancel_if got=%h exp=e1", d);
        end
        // start+commit together in idle is a start only
        bus_write(16'hFFFF, 8'h01);
        irq_ack_start = 1; irq_ack_commit = 1;
        cycle();
        checks++;
        if (irq_vec_valid !== 1'b0) begin
            errors++; $display("FAIL start_commit_same got=%b exp=0", irq_vec_valid);
        end
        irq_ack_commit = 1;
        cycle();
        checks++;
        if (irq_vec !== 16'h0040 || irq_vec_valid !== 1'b1) begin
            errors++; $display("FAIL start_then_commit got=%h/%b exp=0040/1", irq_vec, irq_vec_valid);
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] d;
        logic v;
        do_reset();
        bus_write(16'hFF0F, 8'h02);
        irq_src = 5'b00010;
        bus_write(16'hFF0F, 8'h00);
        irq_src = 0;
        bus_read(16'hFF0F, d, v);
        checks++;
        if (d !== 8'hE2 || v !== 1'b1) begin
            errors++; $display("FAIL set_wins got=%h/%b exp=e2/1", d, v);
        end
    endtask

    task automatic test_pending();
        logic [7:0] d;
        logic v;
        do_reset();
        bus_write(16'hFF0F, 8'h10);
        checks++;
        if (irq_pending !== 1'b0 || halt_wake !== 1'b0) begin
            errors++; $display("FAIL pend_masked got=%b/%b exp=0/0", irq_pending, halt_wake);
        end
        bus_write(16'hFFFF, 8'h10);
        checks++;
        if (irq_pending !== 1'b1 || halt_wake !== 1'b1) begin
            errors++; $display("FAIL pend_enabled got=%b/%b exp=1/1", irq_pending, halt_wake);
        end
        bus_write(16'hFFFF, 8'hFF);
        bus_read(16'hFFFF, d, v);
        checks++;
        if (d !== 8'hFF || v !== 1'b1) begin
            errors++; $display("FAIL ie_read got=%h/%b exp=ff/1", d, v);
        end
        bus_read(16'h1234, d, v);
        checks++;
        if (d !== 8'hFF || v !== 1'b0) begin
            errors++; $display("FAIL miss_read got=%h/%b exp=ff/0", d, v);
        end
    endtask

    task automatic test_held_source();
        logic [7:0] d;
        logic v;
        do_reset();
        irq_src = 5'b00001;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                bus_addr = 16'hFF0F; bus_wdata = 8'h00; bus_wen = 1;
            end
            cycle();
        end
        irq_src = 0;
        bus_read(16'hFF0F, d, v);
        checks++;
`ifdef SM83_IRQ_EDGE_DETECT_EN
        if (d !== 8'hE0) begin
            errors++; $display("FAIL held_edge got=%h exp=e0", d);
        end
`else
        if (d !== 8'hE1) begin
            errors++; $display("FAIL held_level got=%h exp=e1", d);
        end
`endif
    endtask

    task automatic test_rst_mid_dispatch();
        do_reset();
        bus_write(16'hFF0F, 8'h01);
        bus_write(16'hFFFF, 8'h01);
        irq_ack_start = 1;
        cycle();
        irq_ack_commit = 1;
        rst = 1;
        cycle();
        rst = 0;
        irq_ack_commit = 1;
        cycle();
        checks++;
        if (irq_vec_valid !== 1'b0 || irq_vec !== 16'h0000) begin
            errors++; $display("FAIL rst_dispatch got=%h/%b exp=0000/0", irq_vec, irq_vec_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] addrs [3];
        addrs[0] = 16'hFF0F;
        addrs[1] = 16'hFFFF;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            addrs[2] = 16'($urandom);
            rst = ($urandom_range(0, 79) == 0);
            irq_src = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            bus_addr = addrs[$urandom_range(0, 2)];
            bus_wdata = 8'($urandom);
            bus_wen = ($urandom_range(0, 3) == 0);
            bus_ren = ($urandom_range(0, 2) == 0);
            irq_ack_start = ($urandom_range(0, 3) == 0);
            irq_ack_commit = ($urandom_range(0, 3) == 0);
            cycle();
            rst = 0;
            checks++;
            if (irq_pending !== (|(m_if & m_ie[4:0])) ||
                halt_wake !== (|(m_if & m_ie[4:0])) ||
                bus_rvalid !== m_rv || bus_rdata !== m_rd ||
                irq_vec !== m_vec || irq_vec_valid !== m_vv) begin
                errors++;
                $display("FAIL rand_%0d got p=%b w=%b rv=%b rd=%h v=%h vv=%b exp p=%b rv=%b rd=%h v=%h vv=%b",
                         n, irq_pending, halt_wake, bus_rvalid, bus_rdata, irq_vec,
                         irq_vec_valid, |(m_if & m_ie[4:0]), m_rv, m_rd, m_vec, m_vv);
            end
        end
        irq_src = 0;
    endtask

    initial begin
        rst = 0;
        test_reset();
        test_single_dispatch();
        test_priority();
        test_cancel_and_ignore();
        test_set_wins();
        test_pending();
        test_held_source();
        test_rst_mid_dispatch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
